// File: rtl/pwm_peripheral.sv
// 16-channel output driver: each bit is off, static-high or PWM from one shared 8-bit counter.
// The duty value is double-buffered and reloaded only at a period boundary, so no runt pulses occur.
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int unsigned PS_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned OUT_W = 16;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [PS_W-1:0]  prescale_cnt_q, prescale_cnt_d;
  logic [CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [CNT_W-1:0] duty_shadow_q, duty_shadow_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             period_start_q, period_start_d;

  logic [OUT_W-1:0] en_out_c;
  logic [OUT_W-1:0] en_pwm_c;
  logic             pwm_lvl_c;
  logic             tick_c;
  logic             boundary_c;

  // Level and timing strobes derived from registered state only
  always_comb begin
    en_out_c   = {en_reg_out_15_8, en_reg_out_7_0};
    en_pwm_c   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    pwm_lvl_c  = (duty_shadow_q == CNT_LAST) ? 1'b1 : (pwm_cnt_q < duty_shadow_q);
    tick_c     = (state_q == RUN) && (prescale_cnt_q == PS_LAST);
    boundary_c = tick_c && (pwm_cnt_q == CNT_LAST);
  end

  // Next-state: PRIME samples the first duty, RUN free-runs the prescaler and PWM counter
  always_comb begin
    state_d        = state_q;
    prescale_cnt_d = prescale_cnt_q;
    pwm_cnt_d      = pwm_cnt_q;
    duty_shadow_d  = duty_shadow_q;
    period_start_d = 1'b0;
    // en_out=0 wins; otherwise the PWM level or a static high
    out_d          = en_out_c & (~en_pwm_c | {OUT_W{pwm_lvl_c}});

    case (state_q)
      PRIME: begin
        duty_shadow_d  = pwm_duty_cycle;
        prescale_cnt_d = '0;
        pwm_cnt_d      = '0;
        period_start_d = 1'b1;
        out_d          = '0;
        state_d        = RUN;
      end
      RUN: begin
        prescale_cnt_d = tick_c ? '0 : prescale_cnt_q + PS_W'(1);
        if (tick_c) begin
          pwm_cnt_d = pwm_cnt_q + CNT_W'(1);
        end
        if (boundary_c) begin
          duty_shadow_d  = pwm_duty_cycle;
          period_start_d = 1'b1;
        end
      end
      default: begin
        state_d = PRIME;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= PRIME;
      prescale_cnt_q <= '0;
      pwm_cnt_q      <= '0;
      duty_shadow_q  <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      prescale_cnt_q <= prescale_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_shadow_q  <= duty_shadow_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: a CLK_DIV=13 and a CLK_DIV=1 instance share stimulus and are checked
// every cycle against a cycle-count arithmetic model, plus directed duty/period measurements.
module tb_pwm_peripheral;

  logic        clk;
  logic        rst_n;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;
  logic [15:0] out0, out1;
  logic        ps0, ps1;

  int total;
  int bad;

  pwm_peripheral u0 (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_reg_out_7_0 (en_out[7:0]),
    .en_reg_out_15_8(en_out[15:8]),
    .en_reg_pwm_7_0 (en_pwm[7:0]),
    .en_reg_pwm_15_8(en_pwm[15:8]),
    .pwm_duty_cycle (duty),
    .out            (out0),
    .period_start   (ps0)
  );

  pwm_peripheral #(.CLK_DIV(1)) u1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_reg_out_7_0 (en_out[7:0]),
    .en_reg_out_15_8(en_out[15:8]),
    .en_reg_pwm_7_0 (en_pwm[7:0]),
    .en_reg_pwm_15_8(en_pwm[15:8]),
    .pwm_duty_cycle (duty),
    .out            (out1),
    .period_start   (ps1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] get_out(input int idx);
    return (idx == 0) ? out0 : out1;
  endfunction

  function automatic logic get_ps(input int idx);
    return (idx == 0) ? ps0 : ps1;
  endfunction

  // Model: after release, edge 1 primes; edge k>=2 sees run-cycle t=k-2, counter=(t/div)%256
  int          k_m[2];
  logic [7:0]  shadow_m[2];
  logic [15:0] exp_out[2];
  logic        exp_ps[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int   div;
      int   t;
      int   cnt;
      logic lvl;
      div = (i == 0) ? 13 : 1;
      if (!rst_n) begin
        k_m[i]      = 0;
        shadow_m[i] = 8'h00;
        exp_out[i]  = 16'h0000;
        exp_ps[i]   = 1'b0;
      end else if (k_m[i] == 0) begin
        shadow_m[i] = duty;
        exp_out[i]  = 16'h0000;
        exp_ps[i]   = 1'b1;
        k_m[i]      = 1;
      end else begin
        t   = k_m[i] - 1;
        cnt = (t / div) % 256;
        lvl = (shadow_m[i] == 8'hFF) || (cnt < int'(shadow_m[i]));
        for (int b = 0; b < 16; b++)
          exp_out[i][b] = en_out[b] ? (en_pwm[b] ? lvl : 1'b1) : 1'b0;
        exp_ps[i] = ((t % div) == div - 1) && (cnt == 255);
        if (exp_ps[i]) shadow_m[i] = duty;
        k_m[i] = k_m[i] + 1;
      end
    end
    #1;
    chk("model_out0", 32'(out0), 32'(exp_out[0]));
    chk("model_ps0",  32'(ps0),  32'(exp_ps[0]));
    chk("model_out1", 32'(out1), 32'(exp_out[1]));
    chk("model_ps1",  32'(ps1),  32'(exp_ps[1]));
  end

  // Counts out[0]-high cycles and period_start pulses over n cycles, optionally changing duty
  task automatic count_high(input int idx, input int n, input int chg_at, input logic [7:0] chg_val,
                            output int hi, output int nps, output int last_ps);
    hi = 0; nps = 0; last_ps = -1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (get_out(idx)[0]) hi++;
      if (get_ps(idx)) begin
        nps++;
        last_ps = c;
      end
      if (c == chg_at) duty = chg_val;
    end
  endtask

  task automatic wait_ps(input int idx, input int max_cyc);
    int   n;
    logic seen;
    n = 0; seen = 1'b0;
    while (!seen && n < max_cyc) begin
      @(negedge clk);
      n++;
      seen = get_ps(idx);
    end
    chk("wait_period_start", 32'(seen), 32'd1);
  endtask

  initial begin
    int hi, nps, last;
    total = 0; bad = 0;
    rst_n = 1'b0; en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h80;
    repeat (3) @(negedge clk);
    chk("reset_out", 32'(out0), 32'd0);
    chk("reset_ps",  32'(ps0),  32'd0);

    // Release: prime pulse on clk 1, 50% duty, next pulse 3328 clk later
    rst_n = 1'b1;
    @(negedge clk);
    chk("prime_ps",  32'(ps0),  32'd1);
    chk("prime_out", 32'(out0), 32'd0);
    count_high(0, 3328, -1, 8'h00, hi, nps, last);
    chk("duty80_high", 32'(hi), 32'd1664);
    chk("period_pulses", 32'(nps), 32'd1);
    chk("period_len", 32'(last), 32'd3328);

    // Static enables take effect one clk later
    en_out = 16'h8001; en_pwm = 16'h0000;
    @(negedge clk);
    chk("static_on", 32'(out0), 32'h8001);
    en_out = 16'h0000;
    @(negedge clk);
    chk("static_off", 32'(out0), 32'h0000);

    // Duty 0x00 over 3 periods, then 0xFF over 2 periods
    en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h00;
    wait_ps(0, 3400);
    count_high(0, 3 * 3328, -1, 8'h00, hi, nps, last);
    chk("duty00_high", 32'(hi), 32'd0);
    duty = 8'hFF;
    wait_ps(0, 3400);
    count_high(0, 2 * 3328, -1, 8'h00, hi, nps, last);
    chk("dutyFF_high", 32'(hi), 32'd6656);
    chk("dutyFF_pulses", 32'(nps), 32'd2);

    // Mid-period change 0x40 -> 0xC0 applies only at the next boundary
    duty = 8'h40;
    wait_ps(0, 3400);
    count_high(0, 3328, 100, 8'hC0, hi, nps, last);
    chk("duty40_high", 32'(hi), 32'd832);
    count_high(0, 3328, -1, 8'h00, hi, nps, last);
    chk("dutyC0_high", 32'(hi), 32'd2496);

    // Async reset mid-run clears outputs immediately
    en_out = 16'h8001; en_pwm = 16'h0001;
    repeat (2) @(negedge clk);
    chk("pre_reset_bit15", 32'(out0[15]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out0", 32'(out0), 32'd0);
    chk("async_rst_ps0",  32'(ps0),  32'd0);
    chk("async_rst_out1", 32'(out1), 32'd0);

    // CLK_DIV=1: duty 0x01 is high 1 clk per 256; bit 5 static high
    duty = 8'h01; en_out = 16'h0021; en_pwm = 16'h0001;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("div1_prime_ps", 32'(ps1), 32'd1);
    count_high(1, 256, -1, 8'h00, hi, nps, last);
    chk("div1_high", 32'(hi), 32'd1);
    chk("div1_period_len", 32'(last), 32'd256);
    duty = 8'h00;
    repeat (3) @(negedge clk);
    chk("div1_bit5_static", 32'(out1[5]), 32'd1);
    chk("div13_bit5_static", 32'(out0[5]), 32'd1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
